// File: rtl/uart_word_loader.sv
// uart_word_loader: parses a little-endian UART load image (addr, count, data) and writes
// the assembled 32-bit words to memory over a req/gnt port with one word of buffering.
module uart_word_loader #(
  parameter logic [31:0] MAX_WORDS      = 32'h0000_4000,
  parameter bit          ADDR_ALIGN_CHK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_char,
  input  logic        uart_w_valid,
  input  logic        uart_done,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  output logic [31:0] words_written,
  output logic        load_done,
  output logic        load_err,
  output logic [1:0]  err_code
);
  typedef enum logic [2:0] {HDR_ADDR, HDR_CNT, DATA, DONE, ERROR} state_t;

  state_t      state, state_d;
  logic [1:0]  idx, code_d;
  logic [31:0] asm_q, start_addr, remaining, rx_left, word;
  logic        asm_full, done_q;
  logic        take, ovf, accept, last, grant, done_rise, fin, misalign, bad_cnt;

  assign take      = uart_w_valid && !uart_done &&
                     (state == HDR_ADDR || state == HDR_CNT || (state == DATA && rx_left != 32'd0));
  assign ovf       = take && state == DATA && asm_full;
  assign accept    = take && !ovf;
  assign last      = accept && idx == 2'd3;
  assign word      = {uart_char, asm_q[31:8]};
  assign grant     = mem_req && mem_gnt;
  assign done_rise = uart_done && !done_q;
  assign fin       = state == DATA && grant && remaining == 32'd1;
  assign misalign  = ADDR_ALIGN_CHK && word[1:0] != 2'd0;
  assign bad_cnt   = word > MAX_WORDS;
  assign mem_be    = {4{mem_req}};
  assign load_done = state == DONE;
  assign load_err  = state == ERROR;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HDR_ADDR;
    else state <= state_d;

  always_comb begin
    state_d = state;
    code_d  = err_code;
    case (state)
      HDR_ADDR: begin
        if (done_rise) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else if (last) begin
          state_d = misalign ? ERROR : HDR_CNT;
          code_d  = misalign ? 2'd2 : err_code;
        end
      end
      HDR_CNT: begin
        if (done_rise) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else if (last) begin
          state_d = bad_cnt ? ERROR : (word == 32'd0) ? DONE : DATA;
          code_d  = bad_cnt ? 2'd2 : err_code;
        end
      end
      DATA: begin
        if (fin) begin
          state_d = DONE;
        end else if (done_rise) begin
          state_d = ERROR;
          code_d  = 2'd3;
        end else if (ovf) begin
          state_d = ERROR;
          code_d  = 2'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= 2'd0;
      asm_q         <= 32'd0;
      asm_full      <= 1'b0;
      done_q        <= 1'b0;
      start_addr    <= 32'd0;
      remaining     <= 32'd0;
      rx_left       <= 32'd0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'd0;
      mem_wdata     <= 32'd0;
      words_written <= 32'd0;
      err_code      <= 2'd0;
    end else begin
      done_q   <= uart_done;
      err_code <= code_d;
      if (accept) begin
        asm_q <= word;
        idx   <= idx + 2'd1;
      end
      if (last && state == HDR_ADDR) start_addr <= word;
      if (last && state == HDR_CNT) begin
        mem_addr  <= start_addr;
        remaining <= word;
        rx_left   <= word;
      end
      if (state == DATA) begin
        // a completed word goes straight to the write buffer when it is free or being granted now
        if (last) begin
          rx_left <= rx_left - 32'd1;
          if (!mem_req || grant) begin
            mem_wdata <= word;
            mem_req   <= 1'b1;
          end else begin
            asm_full <= 1'b1;
          end
        end else if (grant) begin
          mem_req  <= asm_full;
          if (asm_full) mem_wdata <= asm_q;
          asm_full <= 1'b0;
        end
        if (grant) begin
          mem_addr      <= mem_addr + 32'd4;
          words_written <= words_written + 32'd1;
          remaining     <= remaining - 32'd1;
        end
      end
      if (state_d == ERROR || state_d == DONE) mem_req <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_word_loader.sv
// tb_uart_word_loader: directed scenario tasks for the UART load-image word loader.
module tb_uart_word_loader;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  uart_char = 8'd0;
  logic        uart_w_valid = 1'b0, uart_done = 1'b0, mem_gnt = 1'b0;
  logic        mem_req, load_done, load_err;
  logic [31:0] mem_addr, mem_wdata, words_written;
  logic [3:0]  mem_be;
  logic [1:0]  err_code;
  int          vec = 0, errs = 0, req_cycles = 0, be_bad = 0;
  logic [31:0] wa[$], wd[$];

  uart_word_loader dut (
    .clk(clk), .rst_n(rst_n), .uart_char(uart_char), .uart_w_valid(uart_w_valid),
    .uart_done(uart_done), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .words_written(words_written),
    .load_done(load_done), .load_err(load_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // log every write that the next rising edge will accept
  always @(negedge clk) begin
    if (mem_req && mem_gnt) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (mem_req) req_cycles++;
    if (mem_be !== {4{mem_req}}) be_bad++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    uart_char = b;
    uart_w_valid = 1'b1;
    step();
    uart_w_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      send(b);
      repeat (gap) step();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    uart_w_valid = 1'b0;
    uart_done = 1'b0;
    mem_gnt = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    vec++; if ({mem_req, mem_be, load_done, load_err, err_code} !== 9'd0) begin errs++; $display("FAIL reset_flags got %b want 0", {mem_req, mem_be, load_done, load_err, err_code}); end
    vec++; if ({mem_addr, mem_wdata} !== 64'd0) begin errs++; $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata}); end
    vec++; if (words_written !== 32'd0) begin errs++; $display("FAIL reset_count got %0d want 0", words_written); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int base, bb;
    do_reset();
    base = wa.size();
    bb = be_bad;
    mem_gnt = 1'b1;
    send_word(32'h0, 0);
    send_word(32'h2, 0);
    send_word(32'h13, 0);
    send_word(32'h6F, 0);
    repeat (3) step();
    vec++; if (wa.size() - base !== 2) begin errs++; $display("FAIL basic_nwrites got %0d want 2", wa.size() - base); end
    if (wa.size() - base == 2) begin
      vec++; if (wa[base] !== 32'h0 || wd[base] !== 32'h13) begin errs++; $display("FAIL basic_w0 got %h/%h want 00000000/00000013", wa[base], wd[base]); end
      vec++; if (wa[base+1] !== 32'h4 || wd[base+1] !== 32'h6F) begin errs++; $display("FAIL basic_w1 got %h/%h want 00000004/0000006f", wa[base+1], wd[base+1]); end
    end
    vec++; if (words_written !== 32'd2) begin errs++; $display("FAIL basic_count got %0d want 2", words_written); end
    vec++; if (load_done !== 1'b1 || load_err !== 1'b0) begin errs++; $display("FAIL basic_done got %b%b want 10", load_done, load_err); end
    vec++; if (be_bad !== bb) begin errs++; $display("FAIL basic_be got %0d bad cycles want 0", be_bad - bb); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(32'h0010_0000, 31);
    send_word(32'd3, 31);
    send_word(32'hA1A2_A3A4, 31);
    send_word(32'hB1B2_B3B4, 31);
    vec++; if (mem_req !== 1'b1 || load_err !== 1'b0) begin errs++; $display("FAIL ovf_pending got req=%b err=%b want 1 0", mem_req, load_err); end
    vec++; if (mem_addr !== 32'h0010_0000 || mem_wdata !== 32'hA1A2_A3A4) begin errs++; $display("FAIL ovf_hold got %h/%h want 00100000/a1a2a3a4", mem_addr, mem_wdata); end
    send(8'hC4);
    vec++; if (load_err !== 1'b1 || err_code !== 2'd1) begin errs++; $display("FAIL ovf_err got %b/%0d want 1/1", load_err, err_code); end
    vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL ovf_req got %b want 0", mem_req); end
    mem_gnt = 1'b1;
    repeat (10) step();
    vec++; if (words_written !== 32'd0 || load_err !== 1'b1) begin errs++; $display("FAIL ovf_late_gnt got %0d/%b want 0/1", words_written, load_err); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_zero_count();
    int rc;
    do_reset();
    rc = req_cycles;
    mem_gnt = 1'b1;
    send_word(32'h100, 0);
    send(8'h00); send(8'h00); send(8'h00);
    vec++; if (load_done !== 1'b0) begin errs++; $display("FAIL zero_early got %b want 0", load_done); end
    send(8'h00);
    vec++; if (load_done !== 1'b1) begin errs++; $display("FAIL zero_done got %b want 1", load_done); end
    send_word(32'hDEAD_BEEF, 0);
    step();
    vec++; if (req_cycles !== rc || load_done !== 1'b1 || load_err !== 1'b0) begin errs++; $display("FAIL zero_noreq got %0d req cycles done=%b err=%b want 0 1 0", req_cycles - rc, load_done, load_err); end
    mem_gnt = 1'b0;
  endtask

  task automatic test_bad_header();
    int base;
    do_reset();
    base = wa.size();
    mem_gnt = 1'b1;
    send(8'h02); send(8'h00); send(8'h00);
    vec++; if (load_err !== 1'b0) begin errs++; $display("FAIL align_early got %b want 0", load_err); end
    send(8'h00);
    vec++; if (load_err !== 1'b1 || err_code !== 2'd2) begin errs++; $display("FAIL align_err got %b/%0d want 1/2", load_err, err_code); end
    send_word(32'd1, 0);
    send_word(32'h5, 0);
    step();
    vec++; if (wa.size() !== base || words_written !== 32'd0) begin errs++; $display("FAIL align_nowrite got %0d/%0d want 0/0", wa.size() - base, words_written); end
    do_reset();
    send_word(32'h0, 0);
    send_word(32'h0000_4001, 0);
    vec++; if (load_err !== 1'b1 || err_code !== 2'd2) begin errs++; $display("FAIL cnt_big got %b/%0d want 1/2", load_err, err_code); end
    do_reset();
    send_word(32'h0, 0);
    send_word(32'h0000_4000, 0);
    vec++; if (load_err !== 1'b0 || load_done !== 1'b0) begin errs++; $display("FAIL cnt_max got err=%b done=%b want 0 0", load_err, load_done); end
  endtask

  task automatic test_early_done();
    int base, rc;
    do_reset();
    base = wa.size();
    mem_gnt = 1'b1;
    send_word(32'h200, 0);
    send_word(32'd4, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    repeat (2) step();
    vec++; if (words_written !== 32'd2 || load_err !== 1'b0) begin errs++; $display("FAIL early_pre got %0d/%b want 2/0", words_written, load_err); end
    rc = req_cycles;
    uart_done = 1'b1;
    uart_w_valid = 1'b1;
    uart_char = 8'h55;
    repeat (6) step();
    vec++; if (load_err !== 1'b1 || err_code !== 2'd3) begin errs++; $display("FAIL early_err got %b/%0d want 1/3", load_err, err_code); end
    vec++; if (words_written !== 32'd2 || mem_req !== 1'b0 || req_cycles !== rc) begin errs++; $display("FAIL early_quiet got %0d/%b/%0d want 2/0/0", words_written, mem_req, req_cycles - rc); end
    if (wa.size() - base == 2) begin
      vec++; if (wa[base+1] !== 32'h204 || wd[base+1] !== 32'h2222_2222) begin errs++; $display("FAIL early_w1 got %h/%h want 00000204/22222222", wa[base+1], wd[base+1]); end
    end
    uart_done = 1'b0;
    uart_w_valid = 1'b0;
    mem_gnt = 1'b0;
  endtask

  task automatic test_stall_wrap();
    int base;
    do_reset();
    base = wa.size();
    send_word(32'hFFFF_FFF8, 0);
    send_word(32'd3, 0);
    send_word(32'hCAFE_0001, 0);
    vec++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFF8) begin errs++; $display("FAIL stall_lat got %b/%h want 1/fffffff8", mem_req, mem_addr); end
    send_word(32'hCAFE_0002, 0);
    vec++; if (mem_wdata !== 32'hCAFE_0001 || words_written !== 32'd0) begin errs++; $display("FAIL stall_hold got %h/%0d want cafe0001/0", mem_wdata, words_written); end
    mem_gnt = 1'b1;
    step();
    vec++; if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || mem_wdata !== 32'hCAFE_0002) begin errs++; $display("FAIL stall_refill got %b/%h/%h want 1/fffffffc/cafe0002", mem_req, mem_addr, mem_wdata); end
    step();
    vec++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || words_written !== 32'd2) begin errs++; $display("FAIL stall_wrap got %b/%h/%0d want 0/00000000/2", mem_req, mem_addr, words_written); end
    send_word(32'hCAFE_0003, 0);
    repeat (2) step();
    vec++; if (load_done !== 1'b1 || words_written !== 32'd3) begin errs++; $display("FAIL stall_done got %b/%0d want 1/3", load_done, words_written); end
    if (wa.size() - base == 3) begin
      vec++; if (wa[base+2] !== 32'h0 || wd[base+2] !== 32'hCAFE_0003) begin errs++; $display("FAIL stall_w2 got %h/%h want 00000000/cafe0003", wa[base+2], wd[base+2]); end
    end else begin
      vec++; errs++; $display("FAIL stall_nwrites got %0d want 3", wa.size() - base);
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    do_reset();
    base = wa.size();
    send_word(32'h40, 0);
    send_word(32'd2, 0);
    send_word(32'h1122_3344, 0);
    send(8'hDD); send(8'hCC); send(8'hBB);
    uart_char = 8'hAA;
    uart_w_valid = 1'b1;
    mem_gnt = 1'b1;
    step();
    uart_w_valid = 1'b0;
    mem_gnt = 1'b0;
    vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h44 || mem_wdata !== 32'hAABB_CCDD) begin errs++; $display("FAIL b2b_swap got %b/%h/%h want 1/00000044/aabbccdd", mem_req, mem_addr, mem_wdata); end
    vec++; if (words_written !== 32'd1 || load_err !== 1'b0) begin errs++; $display("FAIL b2b_count got %0d/%b want 1/0", words_written, load_err); end
    mem_gnt = 1'b1;
    repeat (2) step();
    vec++; if (load_done !== 1'b1 || words_written !== 32'd2) begin errs++; $display("FAIL b2b_done got %b/%0d want 1/2", load_done, words_written); end
    if (wa.size() - base == 2) begin
      vec++; if (wa[base] !== 32'h40 || wd[base] !== 32'h1122_3344) begin errs++; $display("FAIL b2b_w0 got %h/%h want 00000040/11223344", wa[base], wd[base]); end
    end else begin
      vec++; errs++; $display("FAIL b2b_nwrites got %0d want 2", wa.size() - base);
    end
    mem_gnt = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    send_word(32'h0, 0);
    send_word(32'd2, 0);
    send_word(32'h77, 0);
    vec++; if (mem_req !== 1'b1) begin errs++; $display("FAIL mid_req got %b want 1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if ({mem_req, mem_be, load_done, load_err, err_code} !== 9'd0 || {mem_addr, mem_wdata, words_written} !== 96'd0) begin errs++; $display("FAIL mid_clear got %b %h want all 0", {mem_req, mem_be, load_done, load_err, err_code}, {mem_addr, mem_wdata, words_written}); end
    step();
    rst_n = 1'b1;
    step();
    base = wa.size();
    mem_gnt = 1'b1;
    send_word(32'h0, 0);
    send_word(32'd2, 0);
    send_word(32'h13, 0);
    send_word(32'h6F, 0);
    repeat (3) step();
    vec++; if (load_done !== 1'b1 || words_written !== 32'd2) begin errs++; $display("FAIL mid_reload got %b/%0d want 1/2", load_done, words_written); end
    if (wa.size() - base == 2) begin
      vec++; if (wa[base] !== 32'h0 || wd[base] !== 32'h13 || wa[base+1] !== 32'h4 || wd[base+1] !== 32'h6F) begin errs++; $display("FAIL mid_writes got %h/%h %h/%h want 0/13 4/6f", wa[base], wd[base], wa[base+1], wd[base+1]); end
    end else begin
      vec++; errs++; $display("FAIL mid_nwrites got %0d want 2", wa.size() - base);
    end
    mem_gnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_count();
    test_bad_header();
    test_early_done();
    test_stall_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
